// File: rtl/fp_div_operand_sequencer_if.sv
// fp_div_operand_sequencer_if: divider handshake bundle between the operand sequencer and the FP divider
//   start  : one-cycle start pulse to the divider
//   a, b   : dividend / divisor
//   done   : divider result valid
//   result : quotient
interface fp_div_operand_sequencer_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [31:0] result;
  modport master (output start, a, b, input done, result);
  modport slave (input start, a, b, output done, result);
endinterface

// File: rtl/fp_div_operand_sequencer.sv
// fp_div_operand_sequencer: captures two fp32 operands from switches, starts the divider, latches the quotient for display
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   sw        : switch half-word captured on each load press
//   btn_load  : raw load pushbutton
//   btn_go    : raw go pushbutton
//   div       : divider handshake (start, a, b out; done, result in)
//   data      : registered 32-bit display word
//   state_led : current FSM state encoding
module fp_div_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [15:0]                        sw,
  input  logic                               btn_load,
  input  logic                               btn_go,
  fp_div_operand_sequencer_if.master         div,
  output logic [31:0]                        data,
  output logic [2:0]                         state_led
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {ENT_AH, ENT_AL, ENT_BH, ENT_BL, READY, START, WAIT, SHOW} state_t;
  state_t state, state_nx;
  logic [1:0] raw, s1, s2, lvl, pulse;
  logic [DW-1:0] cnt [2];
  logic load_p, go_p, timeout, alt;
  logic [TW-1:0] tcnt;
  logic [31:0] a, b, res;
  assign raw = {btn_go, btn_load};
  assign load_p = pulse[0];
  assign go_p = pulse[1];
  assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign div.start = state == START;
  assign div.a = a;
  assign div.b = b;
  assign state_led = state;
  // Level follows the synchronised input only after DEBOUNCE_CYCLES consecutive
  // differing samples; the pulse fires on the accepted 0->1 change only.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      pulse <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (s2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          lvl[i] <= s2[i];
          pulse[i] <= s2[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ENT_AH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ENT_AH: state_nx = load_p ? ENT_AL : ENT_AH;
      ENT_AL: state_nx = load_p ? ENT_BH : ENT_AL;
      ENT_BH: state_nx = load_p ? ENT_BL : ENT_BH;
      ENT_BL: state_nx = load_p ? READY : ENT_BL;
      READY:  state_nx = go_p ? START : load_p ? ENT_AH : READY;
      START:  state_nx = WAIT;
      WAIT:   state_nx = (div.done || timeout) ? SHOW : WAIT;
      SHOW:   state_nx = go_p ? ENT_AH : SHOW;
      default: state_nx = ENT_AH;
    endcase
  end
  // Display word lags the operand registers by one cycle; res keeps the
  // quotient (or error word) so SHOW can toggle back to it.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a <= '0;
      b <= '0;
      data <= '0;
      res <= '0;
      alt <= 1'b0;
      tcnt <= '0;
    end else begin
      tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
      case (state)
        ENT_AH: begin
          if (load_p) a[31:16] <= sw;
          data <= a;
        end
        ENT_AL: begin
          if (load_p) a[15:0] <= sw;
          data <= a;
        end
        ENT_BH: begin
          if (load_p) b[31:16] <= sw;
          data <= b;
        end
        ENT_BL: begin
          if (load_p) b[15:0] <= sw;
          data <= b;
        end
        READY: data <= {a[31:16], b[31:16]};
        WAIT: begin
          alt <= 1'b0;
          if (div.done) begin
            data <= div.result;
            res <= div.result;
          end else if (timeout) begin
            data <= 32'hEEEE_EEEE;
            res <= 32'hEEEE_EEEE;
          end
        end
        SHOW:
          if (load_p && !go_p) begin
            alt <= ~alt;
            data <= alt ? res : {a[31:16], b[31:16]};
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fp_div_operand_sequencer.sv
// tb_fp_div_operand_sequencer: scoreboard bench for the operand sequencer with fast debounce/timeout
module tb_fp_div_operand_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] sw = '0;
  logic btn_load = 1'b0;
  logic btn_go = 1'b0;
  logic [31:0] data;
  logic [2:0] state_led;
  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [31:0] exp_q[$];
  fp_div_operand_sequencer_if div_if();
  fp_div_operand_sequencer #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_load(btn_load), .btn_go(btn_go),
    .div(div_if.master), .data(data), .state_led(state_led)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (div_if.start) start_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_state(input string tag, input logic [2:0] st, input int lim);
    int n = 0;
    while (state_led !== st && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state_led), 32'(st));
  endtask
  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) chk({tag, " sb empty"}, data, ~data);
    else chk(tag, data, exp_q.pop_front());
  endtask
  task automatic press_load(input logic [15:0] v);
    sw = v;
    btn_load = 1'b1;
    cyc(10);
    btn_load = 1'b0;
    cyc(10);
  endtask
  task automatic press_go();
    btn_go = 1'b1;
    cyc(10);
    btn_go = 1'b0;
    cyc(10);
  endtask
  task automatic load4(input logic [31:0] va, input logic [31:0] vb);
    press_load(va[31:16]);
    press_load(va[15:0]);
    press_load(vb[31:16]);
    press_load(vb[15:0]);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    div_if.done = 1'b0;
    div_if.result = '0;
    cyc(3);
    chk("reset state", 32'(state_led), 32'd0);
    chk("reset data", data, 32'h0);
    chk("reset start", 32'(div_if.start), 32'd0);
    chk("reset a", div_if.a, 32'h0);
    reset = 1'b1;
    cyc(2);
    press_load(16'h3F80);
    chk("after AH", 32'(state_led), 32'd1);
    press_load(16'h0000);
    chk("after AL", 32'(state_led), 32'd2);
    press_load(16'h4000);
    chk("after BH", 32'(state_led), 32'd3);
    press_load(16'h0000);
    chk("ready state", 32'(state_led), 32'd4);
    chk("div_a", div_if.a, 32'h3F80_0000);
    chk("div_b", div_if.b, 32'h4000_0000);
    chk("ready data", data, 32'h3F80_4000);
    start_cnt = 0;
    exp_q.push_back(32'h3F00_0000);
    btn_go = 1'b1;
    wait_state("enter wait", 3'd6, 40);
    cyc(3);
    div_if.result = 32'h3F00_0000;
    div_if.done = 1'b1;
    cyc(1);
    div_if.done = 1'b0;
    wait_state("show after done", 3'd7, 5);
    pop_chk("result data");
    btn_go = 1'b0;
    cyc(10);
    chk("one start pulse", 32'(start_cnt), 32'd1);
    div_if.done = 1'b1;
    cyc(2);
    div_if.done = 1'b0;
    chk("done ignored in show", data, 32'h3F00_0000);
    press_load(16'hFFFF);
    chk("toggle operands", data, 32'h3F80_4000);
    press_load(16'hFFFF);
    chk("toggle result", data, 32'h3F00_0000);
    press_go();
    chk("restart state", 32'(state_led), 32'd0);
    chk("restart a kept", div_if.a, 32'h3F80_0000);
    chk("restart b kept", div_if.b, 32'h4000_0000);
    chk("restart data", data, 32'h3F80_0000);
    sw = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      btn_load = ~i[0];
      cyc(2);
    end
    btn_load = 1'b1;
    cyc(10);
    btn_load = 1'b0;
    cyc(10);
    chk("bounce one load", 32'(state_led), 32'd1);
    chk("bounce half", div_if.a, 32'h1234_0000);
    press_load(16'h0000);
    press_load(16'h4000);
    press_load(16'h0000);
    chk("ready 2", 32'(state_led), 32'd4);
    exp_q.push_back(32'hEEEE_EEEE);
    btn_go = 1'b1;
    wait_state("enter wait 2", 3'd6, 40);
    begin
      int k = 0;
      while (data !== 32'hEEEE_EEEE && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("timeout latency", 32'(k), 32'd16);
    end
    chk("timeout state", 32'(state_led), 32'd7);
    pop_chk("timeout data");
    btn_go = 1'b0;
    cyc(10);
    press_go();
    load4(32'h4080_0000, 32'h4000_0000);
    chk("ready 3", 32'(state_led), 32'd4);
    exp_q.push_back(32'h4000_0000);
    btn_go = 1'b1;
    btn_load = 1'b1;
    wait_state("go wins over load", 3'd6, 40);
    cyc(15);
    div_if.result = 32'h4000_0000;
    div_if.done = 1'b1;
    cyc(1);
    div_if.done = 1'b0;
    chk("done on last cycle state", 32'(state_led), 32'd7);
    pop_chk("done wins timeout");
    btn_go = 1'b0;
    btn_load = 1'b0;
    cyc(10);
    press_go();
    load4(32'h4110_0000, 32'h3F80_0000);
    start_cnt = 0;
    btn_go = 1'b1;
    wait_state("enter wait 4", 3'd6, 40);
    cyc(3);
    #2 reset = 1'b0;
    #1;
    chk("async reset state", 32'(state_led), 32'd0);
    chk("async reset data", data, 32'h0);
    chk("async reset start", 32'(div_if.start), 32'd0);
    @(negedge clk);
    btn_go = 1'b0;
    reset = 1'b1;
    div_if.result = 32'h1234_5678;
    div_if.done = 1'b1;
    cyc(3);
    div_if.done = 1'b0;
    cyc(2);
    chk("late done state", 32'(state_led), 32'd0);
    chk("late done data", data, 32'h0);
    chk("start count before reset", 32'(start_cnt), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
